// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, redirect kinds and parameter defaults for fetch_ctrl
package fetch_pkg;

  localparam int PC_W_DEF       = 5;
  localparam int BOOT_PC_DEF    = 0;
  localparam int EXC_VECTOR_DEF = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // What the redirect mux decided to act on this cycle
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_BOOT,
    SEL_EXC,
    SEL_ERET,
    SEL_BR,
    SEL_STALL
  } sel_t;

endpackage

// File: rtl/fetch_redirect_mux.sv
// rtl/fetch_redirect_mux.sv - priority select of the Fetch jump/jumpPC request
// Priority: boot > exception > eret > branch > stall; stall is ignored while flushing.
module fetch_redirect_mux
  import fetch_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int BOOT_PC    = BOOT_PC_DEF,
  parameter int EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  state_t          state,
  input  logic            stall_req,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_req,
  input  logic            eret,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [PC_W-1:0] epc,
  output logic            jump,
  output logic [PC_W-1:0] jump_pc,
  output sel_t            sel
);

  always_comb begin
    jump    = 1'b0;
    jump_pc = '0;
    sel     = SEL_NONE;
    if (state == BOOT) begin
      jump    = 1'b1;
      jump_pc = PC_W'(BOOT_PC);
      sel     = SEL_BOOT;
    end else if (exc_req) begin
      jump    = 1'b1;
      jump_pc = PC_W'(EXC_VECTOR);
      sel     = SEL_EXC;
    end else if (eret) begin
      jump    = 1'b1;
      jump_pc = epc;
      sel     = SEL_ERET;
    end else if (br_valid) begin
      jump    = 1'b1;
      jump_pc = br_target;
      sel     = SEL_BR;
    end else if (stall_req && state != FLUSH) begin
      // Re-issue the current PC so the Fetch stage holds
      jump    = 1'b1;
      jump_pc = fetch_pc;
      sel     = SEL_STALL;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage controller: boot, redirects, stalls and flush bubbles
// Exception/eret support and the epc register exist only when FETCH_CTRL_EXC_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int BOOT_PC      = BOOT_PC_DEF,
  parameter int EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_req,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_req,
  input  logic            eret,
  output logic            jump,
  output logic [PC_W-1:0] jump_pc,
  output logic [PC_W-1:0] fetch_pc,
  output logic            ins_valid,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      state
);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q;
  logic            exc_go, eret_go;
  sel_t            sel;

`ifdef FETCH_CTRL_EXC_EN
  logic [PC_W-1:0] epc_d;

  assign exc_go  = exc_req;
  assign eret_go = eret;
  assign epc_d   = (sel == SEL_EXC) ? pc_q : epc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) epc_q <= '0;
    else       epc_q <= epc_d;
  end
`else
  logic unused_exc_inputs;

  assign exc_go            = 1'b0;
  assign eret_go           = 1'b0;
  assign epc_q             = '0;
  assign unused_exc_inputs = exc_req | eret;
`endif

  fetch_redirect_mux #(
    .PC_W       (PC_W),
    .BOOT_PC    (BOOT_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .state     (state_q),
    .stall_req (stall_req),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_req   (exc_go),
    .eret      (eret_go),
    .fetch_pc  (pc_q),
    .epc       (epc_q),
    .jump      (jump),
    .jump_pc   (jump_pc),
    .sel       (sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (sel)
      SEL_BOOT, SEL_EXC, SEL_ERET, SEL_BR: begin
        state_d = FLUSH;
        cnt_d   = 2'(FLUSH_CYCLES);
        pc_d    = jump_pc;
      end
      SEL_STALL: state_d = STALL;
      default: begin
        unique case (state_q)
          RUN:   pc_d = pc_q + PC_W'(1);
          STALL: begin
            state_d = RUN;
            pc_d    = pc_q + PC_W'(1);
          end
          // Shadow PC holds while bubbles drain; the count runs down to 1
          FLUSH: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = RUN;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      pc_q    <= PC_W'(BOOT_PC);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_pc  = pc_q;
  assign epc       = epc_q;
  assign state     = state_q;
  assign ins_valid = (state_q == RUN) || (state_q == STALL);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_req, br_valid, exc_req, eret;
  logic [4:0] br_target;
  logic       jump, ins_valid;
  logic [4:0] jump_pc, fetch_pc, epc;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall_req (stall_req),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .jump      (jump),
    .jump_pc   (jump_pc),
    .fetch_pc  (fetch_pc),
    .ins_valid (ins_valid),
    .epc       (epc),
    .state     (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [4:0] t);
    br_valid  = 1'b1;
    br_target = t;
    tick();
    br_valid  = 1'b0;
    br_target = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_req = 0; br_valid = 0; exc_req = 0; eret = 0; br_target = '0;
    tick(); tick();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (fetch_pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", fetch_pc); end
    n_checks++; if (epc !== 5'd0) begin n_fail++; $display("FAIL reset_epc: got %0d expected 0", epc); end
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", ins_valid); end
  endtask

  task automatic test_boot();
    logic [1:0] exp_state [6] = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1};
    logic       exp_valid [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] exp_pc    [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2};
    reset = 1'b0;
    #1;
    n_checks++; if (jump !== 1'b1 || jump_pc !== 5'd0) begin n_fail++; $display("FAIL boot_jump: got jump=%0b pc=%0d expected 1/0", jump, jump_pc); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (state !== exp_state[i] || ins_valid !== exp_valid[i] || fetch_pc !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL boot_seq[%0d]: got st=%0d v=%0b pc=%0d expected st=%0d v=%0b pc=%0d",
                 i, state, ins_valid, fetch_pc, exp_state[i], exp_valid[i], exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    goto_pc(5'd30);
    tick();
    n_checks++; if (fetch_pc !== 5'd31 || jump !== 1'b0) begin n_fail++; $display("FAIL wrap_pre: got pc=%0d jump=%0b expected 31/0", fetch_pc, jump); end
    tick();
    n_checks++; if (fetch_pc !== 5'd0 || state !== 2'd1) begin n_fail++; $display("FAIL wrap: got pc=%0d st=%0d expected 0/1", fetch_pc, state); end
  endtask

  task automatic test_stall();
    goto_pc(5'd7);
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (jump !== 1'b1 || jump_pc !== 5'd7 || fetch_pc !== 5'd7 || ins_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: got jump=%0b jpc=%0d pc=%0d v=%0b expected 1/7/7/1", i, jump, jump_pc, fetch_pc, ins_valid);
      end
      tick();
    end
    stall_req = 1'b0;
    #1;
    n_checks++; if (state !== 2'd2 || jump !== 1'b0) begin n_fail++; $display("FAIL stall_release: got st=%0d jump=%0b expected 2/0", state, jump); end
    tick();
    n_checks++; if (state !== 2'd1 || fetch_pc !== 5'd8) begin n_fail++; $display("FAIL stall_resume: got st=%0d pc=%0d expected 1/8", state, fetch_pc); end
  endtask

  task automatic test_branch_over_stall();
    br_valid = 1'b1; br_target = 5'd22; stall_req = 1'b1;
    #1;
    n_checks++; if (jump !== 1'b1 || jump_pc !== 5'd22) begin n_fail++; $display("FAIL br_jump: got jump=%0b jpc=%0d expected 1/22", jump, jump_pc); end
    tick();
    br_valid = 1'b0; br_target = '0;
    #1;
    n_checks++; if (state !== 2'd3 || ins_valid !== 1'b0 || fetch_pc !== 5'd22 || jump !== 1'b0 || jump_pc !== 5'd0) begin
      n_fail++; $display("FAIL br_flush1: got st=%0d v=%0b pc=%0d jump=%0b jpc=%0d expected 3/0/22/0/0", state, ins_valid, fetch_pc, jump, jump_pc); end
    tick();
    n_checks++; if (state !== 2'd3 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush2: got st=%0d v=%0b expected 3/0", state, ins_valid); end
    stall_req = 1'b0;
    tick();
    n_checks++; if (fetch_pc !== 5'd22 || ins_valid !== 1'b1) begin n_fail++; $display("FAIL br_run0: got pc=%0d v=%0b expected 22/1", fetch_pc, ins_valid); end
    tick();
    n_checks++; if (fetch_pc !== 5'd23) begin n_fail++; $display("FAIL br_run1: got pc=%0d expected 23", fetch_pc); end
  endtask

  task automatic test_exception();
    goto_pc(5'd12);
    exc_req = 1'b1; br_valid = 1'b1; br_target = 5'd5;
    #1;
`ifdef FETCH_CTRL_EXC_EN
    n_checks++; if (jump !== 1'b1 || jump_pc !== 5'd16) begin n_fail++; $display("FAIL exc_jump: got jump=%0b jpc=%0d expected 1/16", jump, jump_pc); end
    tick();
    exc_req = 1'b0; br_valid = 1'b0;
    n_checks++; if (epc !== 5'd12 || fetch_pc !== 5'd16 || state !== 2'd3) begin n_fail++; $display("FAIL exc_take: got epc=%0d pc=%0d st=%0d expected 12/16/3", epc, fetch_pc, state); end
    tick(); tick(); tick();
    eret = 1'b1;
    #1;
    n_checks++; if (jump !== 1'b1 || jump_pc !== 5'd12) begin n_fail++; $display("FAIL eret_jump: got jump=%0b jpc=%0d expected 1/12", jump, jump_pc); end
    tick();
    eret = 1'b0;
    n_checks++; if (fetch_pc !== 5'd12 || state !== 2'd3) begin n_fail++; $display("FAIL eret_take: got pc=%0d st=%0d expected 12/3", fetch_pc, state); end
`else
    n_checks++; if (jump !== 1'b1 || jump_pc !== 5'd5) begin n_fail++; $display("FAIL exc_ignored: got jump=%0b jpc=%0d expected 1/5", jump, jump_pc); end
    tick();
    exc_req = 1'b0; br_valid = 1'b0;
    n_checks++; if (epc !== 5'd0 || fetch_pc !== 5'd5 || state !== 2'd3) begin n_fail++; $display("FAIL exc_off_take: got epc=%0d pc=%0d st=%0d expected 0/5/3", epc, fetch_pc, state); end
    tick(); tick();
    eret = 1'b1;
    #1;
    n_checks++; if (jump !== 1'b0 || jump_pc !== 5'd0) begin n_fail++; $display("FAIL eret_ignored: got jump=%0b jpc=%0d expected 0/0", jump, jump_pc); end
    tick();
    eret = 1'b0;
    n_checks++; if (fetch_pc !== 5'd6) begin n_fail++; $display("FAIL eret_off_run: got pc=%0d expected 6", fetch_pc); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    goto_pc(5'd3);
    br_valid = 1'b1; br_target = 5'd9;
    tick();
    br_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (state !== 2'd0 || fetch_pc !== 5'd0 || ins_valid !== 1'b0 || epc !== 5'd0) begin
      n_fail++; $display("FAIL async_reset: got st=%0d pc=%0d v=%0b epc=%0d expected 0/0/0/0", state, fetch_pc, ins_valid, epc); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0 || jump !== 1'b1 || jump_pc !== 5'd0) begin n_fail++; $display("FAIL rerelease_boot: got st=%0d jump=%0b jpc=%0d expected 0/1/0", state, jump, jump_pc); end
    tick();
    n_checks++; if (state !== 2'd3 || fetch_pc !== 5'd0) begin n_fail++; $display("FAIL rerelease_flush: got st=%0d pc=%0d expected 3/0", state, fetch_pc); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_wrap();
    test_stall();
    test_branch_over_stall();
    test_exception();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 5: program-counter width, matching the 32-entry instruction memory.
REQ-002 Parameter BOOT_PC, default 0: fetch address after reset.
REQ-003 Parameter EXC_VECTOR, default 16: exception handler address.
REQ-004 Parameter FLUSH_CYCLES, default 2: bubbles marked after any redirect; legal range 1..3.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-high.
- stall_req, in, 1: downstream hazard; hold the current PC.
- br_valid, in, 1: taken-branch redirect request.
- br_target, in, PC_W: branch target.
- exc_req, in, 1: exception request.
- eret, in, 1: return from exception.
- jump, out, 1: drives the Fetch jump input.
- jump_pc, out, PC_W: drives the Fetch jumpPC input.
- fetch_pc, out, PC_W: shadow copy of the Fetch PC.
- ins_valid, out, 1: 0 = the current insReg value is a bubble.
- epc, out, PC_W: saved exception return PC.
- state, out, 2: FSM state encoding.

Function
REQ-006 FSM states: BOOT=0, RUN=1, STALL=2, FLUSH=3.
REQ-007 BOOT lasts exactly one cycle, with jump=1 and jump_pc=BOOT_PC; it then goes to FLUSH.
REQ-008 Request priority each cycle: exc_req > eret > br_valid > stall_req. At most one request is acted on per cycle.
REQ-009 Redirect (exc, eret or branch) in any state except BOOT:
- jump=1, with jump_pc = EXC_VECTOR, epc or br_target respectively.
- fetch_pc takes jump_pc on the next edge.
- FSM enters FLUSH with its counter loaded to FLUSH_CYCLES.
REQ-010 stall_req with no redirect, in RUN or STALL:
- jump=1, jump_pc=fetch_pc, so the Fetch PC is held.
- FSM is in STALL while stall_req is high and returns to RUN on the first cycle stall_req is low.
REQ-011 In RUN with no request: jump=0, and fetch_pc increments by 1 modulo 2^PC_W (31 wraps to 0).
REQ-012 FLUSH:
- ins_valid=0; the counter decrements each cycle; the FSM returns to RUN when the counter reaches 1.
- A new redirect during FLUSH reloads the counter and retargets.
- stall_req during FLUSH is ignored.
REQ-013 ins_valid=1 only in RUN and STALL; it is 0 in BOOT and FLUSH.
REQ-014 On an exc_req redirect, epc latches fetch_pc. An exc_req while already in FLUSH from an exception latches the current fetch_pc.
REQ-015 jump and jump_pc are combinational from the FSM state and inputs. fetch_pc, epc and state are registered.
REQ-016 jump_pc = 0 whenever jump = 0.

Reset
REQ-017 While reset is high, the block is asynchronously forced to: state=BOOT, fetch_pc=BOOT_PC, epc=0, flush counter=0, ins_valid=0.
REQ-018 Asserting reset mid-FLUSH or mid-STALL abandons the operation. Release always restarts at BOOT.

Configuration
REQ-019 Macro FETCH_CTRL_EXC_EN:
- Defined: exc_req, eret and the epc register operate as in REQ-008, REQ-009 and REQ-014.
- Undefined: exc_req and eret are ignored, epc is tied to 0, and the epc register is not synthesised.

Structure
REQ-020 Shared package fetch_pkg holds the FSM state encoding, PC_W, BOOT_PC and EXC_VECTOR defaults.
REQ-021 One sub-module, fetch_redirect_mux: combinational priority select producing jump and jump_pc. The FSM and registers stay in fetch_ctrl.

Verification
REQ-022 Bench shall cover these directed scenarios:
- Reset release -> cycle 0: BOOT, jump=1, jump_pc=0; then 2 cycles of ins_valid=0; then RUN with fetch_pc counting 0,1,2,...
- RUN at fetch_pc=31 with no requests -> fetch_pc=0 on the next cycle, jump=0.
- stall_req high for 3 cycles at fetch_pc=7 -> jump=1 and jump_pc=7 each cycle, fetch_pc stays 7, ins_valid=1; RUN resumes at 8.
- br_valid=1 and br_target=22 together with stall_req=1 -> jump_pc=22, stall ignored, 2 bubbles, then fetch_pc 22,23.
- exc_req=1 at fetch_pc=12 together with br_valid=1 (macro defined) -> jump_pc=16, epc=12; a later eret -> jump_pc=12.
- Same exc_req with the macro undefined -> exc_req ignored, branch taken, epc=0; reset asserted mid-FLUSH -> BOOT on release.
